// File: rtl/hex_clock_ctrl.sv
// Time-set controller: debounced KEY[0]=mode / KEY[1]=increment driving RUN/SET_HH/SET_MM/SET_SS with BCD shadows and digit blink.
// Latency: raw key edge to registered state change is 2 + DEBOUNCE_CYCLES cycles; load_o is a registered pulse on the first RUN cycle.
// No backpressure; HEX_CLOCK_CTRL_TIMEOUT_EN adds an inactivity timeout that abandons an edit and returns to RUN.
module hex_clock_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 12_500_000
`ifdef HEX_CLOCK_CTRL_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 500_000_000
`endif
) (
    input  logic       CLK_50,
    input  logic       rst_ni,
    input  logic [1:0] KEY,
    input  logic [7:0] time_hh_i,
    input  logic [7:0] time_mm_i,
    input  logic [7:0] time_ss_i,
    output logic [7:0] set_hh_o,
    output logic [7:0] set_mm_o,
    output logic [7:0] set_ss_o,
    output logic       load_o,
    output logic       run_o,
    output logic [5:0] blank_o,
    output logic [1:0] mode_o
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BKW = $clog2(BLINK_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BKW-1:0] BK_LAST = BKW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_SET_HH = 2'd1,
        S_SET_MM = 2'd2,
        S_SET_SS = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]       db_lvl_q, db_lvl_d;
    logic [DBW-1:0]   db_cnt_q [2];
    logic [DBW-1:0]   db_cnt_d [2];
    logic [1:0]       press;
    logic             mode_press, inc_press;
    logic [7:0]       hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic             load_q, load_d;
    logic [BKW-1:0]   blink_cnt_q, blink_cnt_d;
    logic             phase_q, phase_d;
    logic [5:0]       blank_mask;
`ifdef HEX_CLOCK_CTRL_TIMEOUT_EN
    localparam logic [28:0] TO_LAST = 29'(TIMEOUT_CYCLES - 1);
    logic [28:0]      to_cnt_q, to_cnt_d;
`endif

    // Out-of-range captures (bad nibble, hh>23, mm/ss>59) restart the edit from 00.
    function automatic logic [7:0] sanitize(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        r = v;
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > max_v)
            r = 8'h00;
        return r;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v >= max_v)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = v + 8'd1;
        return r;
    endfunction

    always_comb begin
        sync1_d = KEY;
        sync2_d = sync1_q;
        press   = 2'b00;
        for (int k = 0; k < 2; k++) begin
            db_lvl_d[k] = db_lvl_q[k];
            db_cnt_d[k] = db_cnt_q[k];
            if (sync2_q[k] == db_lvl_q[k]) begin
                db_cnt_d[k] = '0;
            end else if (db_cnt_q[k] == DB_LAST) begin
                db_lvl_d[k] = sync2_q[k];
                db_cnt_d[k] = '0;
                press[k]    = ~sync2_q[k];
            end else begin
                db_cnt_d[k] = db_cnt_q[k] + 1'b1;
            end
        end
    end

    assign mode_press = press[0];
    assign inc_press  = press[1] & ~press[0];

    always_comb begin
        state_d     = state_q;
        hh_d        = hh_q;
        mm_d        = mm_q;
        ss_d        = ss_q;
        load_d      = 1'b0;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        case (state_q)
            S_RUN: begin
                if (mode_press) begin
                    state_d = S_SET_HH;
                    hh_d    = sanitize(time_hh_i, 8'h23);
                    mm_d    = sanitize(time_mm_i, 8'h59);
                    ss_d    = sanitize(time_ss_i, 8'h59);
                end
            end
            S_SET_HH: begin
                if (mode_press)     state_d = S_SET_MM;
                else if (inc_press) hh_d = bcd_inc(hh_q, 8'h23);
            end
            S_SET_MM: begin
                if (mode_press)     state_d = S_SET_SS;
                else if (inc_press) mm_d = bcd_inc(mm_q, 8'h59);
            end
            default: begin
                if (mode_press) begin
                    state_d = S_RUN;
                    load_d  = 1'b1;
                end else if (inc_press) begin
                    ss_d = bcd_inc(ss_q, 8'h59);
                end
            end
        endcase
`ifdef HEX_CLOCK_CTRL_TIMEOUT_EN
        to_cnt_d = '0;
        if (state_q != S_RUN && press == 2'b00) begin
            if (to_cnt_q == TO_LAST)
                state_d = S_RUN;
            else
                to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
        // Any state entry or increment restarts the blink with the digits visible.
        if (state_d == S_RUN || state_d != state_q || inc_press) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    always_comb begin
        blank_mask = 6'b000000;
        case (state_q)
            S_SET_HH: blank_mask = 6'b110000;
            S_SET_MM: blank_mask = 6'b001100;
            S_SET_SS: blank_mask = 6'b000011;
            default:  blank_mask = 6'b000000;
        endcase
    end

    always_ff @(posedge CLK_50 or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_RUN;
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            db_lvl_q    <= 2'b11;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
            hh_q        <= 8'h00;
            mm_q        <= 8'h00;
            ss_q        <= 8'h00;
            load_q      <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
`ifdef HEX_CLOCK_CTRL_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_lvl_q    <= db_lvl_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
            hh_q        <= hh_d;
            mm_q        <= mm_d;
            ss_q        <= ss_d;
            load_q      <= load_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
`ifdef HEX_CLOCK_CTRL_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign set_hh_o = hh_q;
    assign set_mm_o = mm_q;
    assign set_ss_o = ss_q;
    assign load_o   = load_q;
    assign run_o    = (state_q == S_RUN);
    assign mode_o   = state_q;
    assign blank_o  = phase_q ? blank_mask : 6'b000000;

endmodule
